// File: rtl/aqp_spim_pkg.sv
// Shared types for the aqp_spimaster byte-wide SPI master.
// Optional one-byte transmit holding register: define AQP_SPIM_TXBUF_EN.
package aqp_spim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_LOW   = 2'd2,
        ST_HIGH  = 2'd3
    } spim_state_e;

    localparam int CLK_DIV_MIN = 4;

endpackage

// File: rtl/aqp_spim_tick.sv
// Half-period timer for aqp_spimaster: ticks when the count reaches 0.
module aqp_spim_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    input  logic reload_i,
    output logic tick_o
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == 8'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (reload_i || tick_o) begin
            cnt_d = RELOAD;
        end else if (en_i) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aqp_spimaster.sv
// Mode-0, MSB-first SPI master with software chip select.
// Define AQP_SPIM_TXBUF_EN for a one-byte holding register (gapless SCLK).
module aqp_spimaster
    import aqp_spim_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs_en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       spi_ssel_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    spim_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        ssel_q, ssel_d;
    logic        mosi_q, mosi_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        run_q;
    logic [1:0]  miso_q;
    logic        miso_sync;
    logic        tick;
    logic        accept;
    logic [7:0]  shift_in;

    assign miso_sync = miso_q[1];
    assign shift_in  = {shift_q[6:0], miso_sync};
    assign accept    = tx_valid && tx_ready;

    aqp_spim_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk      (clk),
        .reset_n  (reset_n),
        .en_i     (state_q != ST_IDLE),
        .reload_i (state_q == ST_IDLE),
        .tick_o   (tick)
    );

`ifdef AQP_SPIM_TXBUF_EN
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       byte_end;

    assign byte_end = (state_q == ST_HIGH) && tick && (bitcnt_q == 3'd7);
    assign tx_ready = run_q && !hold_full_q;
    assign busy     = (state_q != ST_IDLE) || hold_full_q;

    // Bytes offered mid-transfer are parked unless the current byte ends now.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (byte_end && hold_full_q) begin
            hold_full_d = 1'b0;
        end else if (accept && (state_q != ST_IDLE) && !byte_end) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end
`else
    assign tx_ready = run_q && (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        ssel_d     = ssel_q;
        mosi_d     = mosi_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ssel_d = ~cs_en;
                if (accept) begin
                    shift_d  = tx_data;
                    bitcnt_d = 3'd0;
                    ssel_d   = 1'b0;
                    state_d  = ssel_q ? ST_SETUP : ST_LOW;
                end
            end
            ST_SETUP: begin
                if (tick) state_d = ST_LOW;
            end
            ST_LOW: begin
                mosi_d = shift_q[7];
                if (tick) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (tick) begin
                    shift_d  = shift_in;
                    bitcnt_d = bitcnt_q + 3'd1;
                    state_d  = ST_LOW;
                    if (bitcnt_q == 3'd7) begin
                        rx_data_d  = shift_in;
                        rx_valid_d = 1'b1;
                        state_d    = ST_IDLE;
`ifdef AQP_SPIM_TXBUF_EN
                        if (hold_full_q || accept) begin
                            shift_d = hold_full_q ? hold_q : tx_data;
                            state_d = ST_LOW;
                        end
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'h00;
            bitcnt_q   <= 3'd0;
            ssel_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            run_q      <= 1'b0;
            miso_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            ssel_q     <= ssel_d;
            mosi_q     <= mosi_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            run_q      <= 1'b1;
            miso_q     <= {miso_q[0], spi_miso};
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign spi_ssel_n = ssel_q;
    assign spi_sclk   = (state_q == ST_HIGH);
    assign spi_mosi   = mosi_q;

endmodule
